item_pickup_manager: RTL

- Consumer of the reward random generator's placement request.
- On `set_require` it latches item type and grid position, shows the item, and detects tank pickup.
- It returns `set_finish` to the generator and drives timed power-up effects to the tank and game logic.
- Sits between the reward generator and the tank/VGA layers.

---
 rtl/item_pkg.sv | 29 ++
 rtl/item_effect_timer.sv | 28 ++
 rtl/item_pickup_manager.sv | 136 +++++++++++++
 3 files changed

// File: rtl/item_pkg.sv
// Shared definitions for the item pickup manager.
// Holds item type codes, FSM state encoding, the default effect duration
// and a helper that maps an item kind onto its timed-effect load vector.
package item_pkg;

  localparam logic [2:0] ITEM_NONE   = 3'd0;
  localparam logic [2:0] ITEM_LIFE   = 3'd1;
  localparam logic [2:0] ITEM_SPEED  = 3'd2;
  localparam logic [2:0] ITEM_FIRE   = 3'd3;
  localparam logic [2:0] ITEM_SHIELD = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // 40 ticks of the 4 Hz enable = 10 s
  localparam int DEF_EFFECT_TICKS = 40;

  // bit0 speed, bit1 rapid fire, bit2 shield; life has no timer
  function automatic logic [2:0] effect_load(input logic [2:0] kind);
    case (kind)
      ITEM_SPEED:  effect_load = 3'b001;
      ITEM_FIRE:   effect_load = 3'b010;
      ITEM_SHIELD: effect_load = 3'b100;
      default:     effect_load = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/item_effect_timer.sv
// Countdown timer for one timed power-up effect.
// Ports: clk/rst (async high), load reloads to TICKS, tick decrements
// while nonzero, active is high while the count is nonzero.
module item_effect_timer #(
  parameter int TICKS = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic active
);

  localparam int W = $clog2(TICKS + 1);

  logic [W-1:0] cnt_q;

  // load has priority over a coincident tick; re-pickup restarts the
  // full duration rather than adding to it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cnt_q <= '0;
    else if (load)                 cnt_q <= W'(TICKS);
    else if (tick && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign active = (cnt_q != '0);

endmodule

// File: rtl/item_pickup_manager.sv
// Item pickup manager: accepts a placement request from the reward
// generator, shows the item, detects the tank driving over it, returns
// set_finish and drives the extra-life pulse and timed effects.
// Ports: clk, rst (async high), tick_4hz enable; set_require/item_type/
// random_xpos/random_ypos from the generator; tank_xpos/tank_ypos from the
// tank; set_finish back to the generator; item_visible/item_xpos/item_ypos/
// item_kind to the map renderer; life_pulse and effect_active to game logic.
module item_pickup_manager
  import item_pkg::*;
#(
  parameter int EFFECT_TICKS = DEF_EFFECT_TICKS,
  parameter int GRID_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_4hz,
  input  logic              set_require,
  input  logic [2:0]        item_type,
  input  logic [GRID_W-1:0] random_xpos,
  input  logic [GRID_W-1:0] random_ypos,
  input  logic [GRID_W-1:0] tank_xpos,
  input  logic [GRID_W-1:0] tank_ypos,
  output logic              set_finish,
  output logic              item_visible,
  output logic [GRID_W-1:0] item_xpos,
  output logic [GRID_W-1:0] item_ypos,
  output logic [2:0]        item_kind,
  output logic              life_pulse,
  output logic [2:0]        effect_active
);

  logic [1:0]        state_q, state_d;
  logic              pend_q,  pend_d;   // request latched, reveal next cycle
  logic              vis_q,   vis_d;
  logic              fin_q,   fin_d;
  logic              life_q,  life_d;
  logic              match_q, match_d;
  logic [2:0]        kind_q,  kind_d;
  logic [GRID_W-1:0] x_q, x_d, y_q, y_d;
  logic [2:0]        load;

  // registered position compare, only meaningful while the item is shown
  assign match_d = (state_q == ST_SHOW) && (tank_xpos == x_q) && (tank_ypos == y_q);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    vis_d   = vis_q;
    fin_d   = fin_q;
    kind_d  = kind_q;
    x_d     = x_q;
    y_d     = y_q;
    life_d  = 1'b0;
    load    = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          vis_d   = 1'b1;
          state_d = ST_SHOW;
        end else if (set_require && item_type != ITEM_NONE) begin
          // type 0 with the request up means the generator has not yet
          // updated type/position, so it is not a real request
          pend_d = 1'b1;
          kind_d = item_type;
          x_d    = random_xpos;
          y_d    = random_ypos;
        end
      end
      ST_SHOW: begin
        // pickup takes priority over a simultaneous generator timeout
        if (match_q) begin
          vis_d   = 1'b0;
          fin_d   = 1'b1;
          life_d  = (kind_q == ITEM_LIFE);
          load    = effect_load(kind_q);
          state_d = ST_ACK;
        end else if (!set_require) begin
          vis_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        // generator samples on a slow clock: hold the level until it drops
        if (!set_require) begin
          fin_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      vis_q   <= 1'b0;
      fin_q   <= 1'b0;
      life_q  <= 1'b0;
      match_q <= 1'b0;
      kind_q  <= ITEM_NONE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      vis_q   <= vis_d;
      fin_q   <= fin_d;
      life_q  <= life_d;
      match_q <= match_d;
      kind_q  <= kind_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_tmr
    item_effect_timer #(.TICKS(EFFECT_TICKS)) u_tmr (
      .clk    (clk),
      .rst    (rst),
      .load   (load[i]),
      .tick   (tick_4hz),
      .active (effect_active[i])
    );
  end

  assign set_finish   = fin_q;
  assign item_visible = vis_q;
  assign item_xpos    = x_q;
  assign item_ypos    = y_q;
  // kind is kept internally for effect decode but only shown while visible
  assign item_kind    = vis_q ? kind_q : ITEM_NONE;
  assign life_pulse   = life_q;

endmodule
